inv_byte_sub: RTL and testbench

- Inverse byte substitution (AES InvSubBytes) for the decryption datapath.
- Counterpart of the encrypt-side byte substitution stage; sits between the inverse shift-rows stage and the round-key/inverse-mix-columns stages of the decrypt round loop.
- Iterative: a shared bank of LANES inverse S-box lookups processes the 128-bit state over 16/LANES cycles, under a start/busy/done handshake.
- In round 0 the operand is data_in XOR key (initial AddRoundKey); in every other round the operand is data_to_store.

---
 rtl/inv_byte_sub.sv | 120 ++++++++++++
 tb/tb_inv_byte_sub.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/inv_byte_sub.sv
// AES InvSubBytes for the decrypt round loop, LANES bytes per clock over a shared S-box bank.
// Latency 16/LANES clocks from accepted start to done; start is ignored while busy (no queueing).
module inv_byte_sub #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [3:0]   count_out,
    input  logic [127:0] data_in,
    input  logic [127:0] data_to_store,
    input  logic [127:0] key,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);
    localparam int CYCLES = 16 / LANES;
    localparam int GRP_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(CYCLES - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_byte_sub: LANES must be 1, 2, 4, 8 or 16");
    end

    // Entry x lives at bits [2047-8x -: 8]; row r holds entries 16r..16r+15.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic {IDLE, SUB} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [GRP_W-1:0]   r_grp;
    logic [127:0]       r_work;
    logic [127:0]       w_work_next;
    logic [127:0]       r_data_out;
    logic               r_done;
    logic               w_last;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    assign w_last = (r_state == SUB) && (r_grp == LAST_GRP);

    // Replace the current group of bytes; byte 0 is the MSB.
    always_comb begin
        w_work_next = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_work_next[127 - 8 * (int'(r_grp) * LANES + l) -: 8] =
                inv_sbox(r_work[127 - 8 * (int'(r_grp) * LANES + l) -: 8]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == IDLE) begin
            if (start) begin
                w_next_state = SUB;
            end
        end else if (w_last) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_grp      <= '0;
            r_work     <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_work <= (count_out == 4'd0) ? (data_in ^ key) : data_to_store;
                    r_grp  <= '0;
                end
            end else begin
                r_work <= w_work_next;
                if (w_last) begin
                    r_grp      <= '0;
                    r_data_out <= w_work_next;
                    r_done     <= 1'b1;
                end else begin
                    r_grp <= r_grp + 1'b1;
                end
            end
        end
    end

    assign busy     = (r_state == SUB);
    assign done     = r_done;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_inv_byte_sub.sv
// Directed bench for inv_byte_sub: default-LANES instance plus a LANES sweep sharing the same stimulus.
module tb_inv_byte_sub;
    localparam int NSW = 4;
    localparam int SW_LANES [NSW] = '{1, 2, 8, 16};
    localparam logic [127:0] KV_IN  = 128'h637C777BF26B6FC53001672BFED7AB76;
    localparam logic [127:0] KV_OUT = 128'h000102030405060708090A0B0C0D0E0F;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [3:0]   count_out;
    logic [127:0] data_in;
    logic [127:0] data_to_store;
    logic [127:0] key;
    logic [127:0] data_out;
    logic         busy;
    logic         done;

    logic [127:0] sw_dout [NSW];
    logic         sw_busy [NSW];
    logic         sw_done [NSW];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inv_byte_sub dut (
        .clk(clk), .n_rst(n_rst), .start(start), .count_out(count_out),
        .data_in(data_in), .data_to_store(data_to_store), .key(key),
        .data_out(data_out), .busy(busy), .done(done)
    );

    for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
        inv_byte_sub #(.LANES(SW_LANES[gi])) u_sw (
            .clk(clk), .n_rst(n_rst), .start(start), .count_out(count_out),
            .data_in(data_in), .data_to_store(data_to_store), .key(key),
            .data_out(sw_dout[gi]), .busy(sw_busy[gi]), .done(sw_done[gi])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; counts cycles and busy samples seen on the way.
    task automatic wait_done(input int lat_init, output int lat, output int nbusy);
        lat   = lat_init;
        nbusy = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic block(input string tag, input logic [127:0] exp);
        int lat, nb;
        pulse_start();
        wait_done(0, lat, nb);
        check({tag, " latency"}, 128'(lat), 128'd4);
        check({tag, " data"}, data_out, exp);
    endtask

    initial begin
        int lat, nb, ndone;
        int slat [NSW];
        logic [127:0] sdat [NSW];

        n_rst = 1'b0; start = 1'b0; count_out = '0;
        data_in = '0; data_to_store = '0; key = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset data_out", data_out, 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Round 0 with data_in == key: operand is zero.
        count_out = 4'd0;
        data_in   = 128'h0123456789ABCDEF0011223344556677;
        key       = 128'h0123456789ABCDEF0011223344556677;
        pulse_start();
        wait_done(0, lat, nb);
        check("r0 latency", 128'(lat), 128'd4);
        check("r0 busy cycles", 128'(nb), 128'd4);
        check("r0 data", data_out, {16{8'h52}});
        @(posedge clk); #1;
        check("r0 done one cycle", 128'(done), 128'd0);
        check("r0 data holds", data_out, {16{8'h52}});

        count_out = 4'd3; data_to_store = KV_IN;
        block("known vector", KV_OUT);

        count_out = 4'd1; data_to_store = {16{8'h16}};
        block("bytes 16", {16{8'hFF}});
        data_to_store = {16{8'hED}};
        block("bytes ED", {16{8'h53}});

        // Inputs change and start re-pulses while the block is in flight.
        count_out = 4'd5; data_to_store = {16{8'h63}};
        data_in = 128'h00112233445566778899AABBCCDDEEFF; key = 128'h1;
        pulse_start();
        check("no partial E0", data_out, {16{8'h53}});
        @(posedge clk); #1;
        count_out = 4'd0; data_to_store = {16{8'h16}};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("no partial E2", data_out, {16{8'h53}});
        wait_done(2, lat, nb);
        check("stable latency", 128'(lat), 128'd4);
        check("stable data", data_out, {16{8'h00}});

        // Start in the done cycle is accepted.
        count_out = 4'd1; data_to_store = {16{8'h16}};
        block("back-to-back", {16{8'hFF}});
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("no extra op", 128'(ndone), 128'd0);

        // Async reset in the middle of a block.
        count_out = 4'd3; data_to_store = KV_IN;
        pulse_start();
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        check("midrst data_out", data_out, 128'd0);
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst done", 128'(done), 128'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("midrst no done", 128'(ndone), 128'd0);
        block("after reset", KV_OUT);

        // LANES sweep from a common reset.
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        count_out = 4'd3; data_to_store = KV_IN;
        for (int i = 0; i < NSW; i++) begin
            slat[i] = -1;
            sdat[i] = '0;
        end
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NSW; i++) begin
                if (sw_done[i] === 1'b1 && slat[i] < 0) begin
                    slat[i] = c;
                    sdat[i] = sw_dout[i];
                end
            end
        end
        for (int i = 0; i < NSW; i++) begin
            check($sformatf("sweep L%0d latency", SW_LANES[i]), 128'(slat[i]), 128'(16 / SW_LANES[i]));
            check($sformatf("sweep L%0d data", SW_LANES[i]), sdat[i], KV_OUT);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
